// File: rtl/regfile_sb_if.sv
// Bus bundle between the ID/WB stages and the regfile_sb register file.
// master = pipeline side (drives indices, writeback and issue), slave = register file.
interface regfile_sb_if #(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 64
);
  logic [IDX_W-1:0]  rs1_id;
  logic [IDX_W-1:0]  rs2_id;
  logic [IDX_W-1:0]  rd_id;
  logic              RegWrite;
  logic [DATA_W-1:0] WBdata;
  logic              issue_valid;
  logic [IDX_W-1:0]  issue_rd;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              DataEqual;
  logic              hazard;
  logic [IDX_W:0]    busy_cnt;

  modport master (
    output rs1_id, rs2_id, rd_id, RegWrite, WBdata, issue_valid, issue_rd,
    input  rs1_data, rs2_data, DataEqual, hazard, busy_cnt
  );

  modport slave (
    input  rs1_id, rs2_id, rd_id, RegWrite, WBdata, issue_valid, issue_rd,
    output rs1_data, rs2_data, DataEqual, hazard, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with a per-register pending-write scoreboard (busy bits).
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 64
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [IDX_W:0]    CNT_MAX   = (IDX_W+1)'(NUM_REGS - 1);

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [IDX_W:0]      busy_cnt_r;
  logic [IDX_W:0]      cnt_nxt_s;
  logic                rs1_byp_s;
  logic                rs2_byp_s;
  logic [DATA_W-1:0]   rs1_data_s;
  logic [DATA_W-1:0]   rs2_data_s;
  logic                hazard_s;

  function automatic logic [IDX_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = {(IDX_W+1){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + (IDX_W+1)'(v[i]);
    end
    return cnt;
  endfunction

  // Read ports, optional writeback forwarding, hazard detection.
  always_comb begin
    rs1_byp_s = 1'b0;
    rs2_byp_s = 1'b0;
`ifdef REGFILE_BYPASS_EN
    rs1_byp_s = bus.RegWrite && (bus.rd_id == bus.rs1_id) && (bus.rs1_id != IDX_ZERO);
    rs2_byp_s = bus.RegWrite && (bus.rd_id == bus.rs2_id) && (bus.rs2_id != IDX_ZERO);
`else
    rs1_byp_s = 1'b0;
    rs2_byp_s = 1'b0;
`endif
    if (bus.rs1_id == IDX_ZERO) begin
      rs1_data_s = DATA_ZERO;
    end else if (rs1_byp_s) begin
      rs1_data_s = bus.WBdata;
    end else begin
      rs1_data_s = regs_r[bus.rs1_id];
    end
    if (bus.rs2_id == IDX_ZERO) begin
      rs2_data_s = DATA_ZERO;
    end else if (rs2_byp_s) begin
      rs2_data_s = bus.WBdata;
    end else begin
      rs2_data_s = regs_r[bus.rs2_id];
    end
    // A forwarded source is already satisfied, so it never stalls ID.
    hazard_s = (busy_r[bus.rs1_id] && (bus.rs1_id != IDX_ZERO) && !rs1_byp_s) ||
               (busy_r[bus.rs2_id] && (bus.rs2_id != IDX_ZERO) && !rs2_byp_s);
  end

  // Next scoreboard state: a same-cycle issue beats the writeback of an older producer.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.issue_valid && (bus.issue_rd == IDX_W'(i))) begin
        busy_nxt_s[i] = 1'b1;
      end else if (bus.RegWrite && (bus.rd_id == IDX_W'(i))) begin
        busy_nxt_s[i] = 1'b0;
      end else begin
        busy_nxt_s[i] = busy_r[i];
      end
    end
    busy_nxt_s[0] = 1'b0;
    cnt_nxt_s = popcount(busy_nxt_s);
    if (cnt_nxt_s > CNT_MAX) begin
      cnt_nxt_s = CNT_MAX;
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
  end

  // Register array write port; x0 storage is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= DATA_ZERO;
      end
    end else if (bus.RegWrite && (bus.rd_id != IDX_ZERO)) begin
      regs_r[bus.rd_id] <= bus.WBdata;
    end
  end

  // Scoreboard vector and its registered population count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r     <= {NUM_REGS{1'b0}};
      busy_cnt_r <= {(IDX_W+1){1'b0}};
    end else begin
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= cnt_nxt_s;
    end
  end

  assign bus.rs1_data  = rs1_data_s;
  assign bus.rs2_data  = rs2_data_s;
  assign bus.DataEqual = (rs1_data_s == rs2_data_s);
  assign bus.hazard    = hazard_s;
  assign bus.busy_cnt  = busy_cnt_r;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, hand-written corner sequences,
// and randomized traffic against an array-based reference model.
module tb_regfile_sb;
  localparam int NR = 32;
  localparam int IW = 5;
  localparam int DW = 64;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  regfile_sb_if #(.IDX_W(IW), .DATA_W(DW)) bus ();

  regfile_sb #(.NUM_REGS(NR), .IDX_W(IW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural contents and outstanding-producer flags.
  logic [DW-1:0] m_reg  [NR];
  bit            m_busy [NR];

  typedef struct {
    logic [IW-1:0] rs1, rs2, rd;
    logic          we;
    logic [DW-1:0] wd;
    logic          iv;
    logic [IW-1:0] ird;
    logic [DW-1:0] e1, e2;
    logic          eq, hz;
    logic [IW:0]   cnt;
  } vec_t;

  vec_t vecs [14];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [IW-1:0] idx);
    if (idx == 0) return '0;
    if (BYP && bus.RegWrite && bus.rd_id == idx) return bus.WBdata;
    return m_reg[idx];
  endfunction

  function automatic bit m_src_hazard(input logic [IW-1:0] idx);
    if (idx == 0 || !m_busy[idx]) return 1'b0;
    if (BYP && bus.RegWrite && bus.rd_id == idx) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
    return (c > NR - 1) ? NR - 1 : c;
  endfunction

  task automatic model_check();
    logic [DW-1:0] e1, e2;
    e1 = m_read(bus.rs1_id);
    e2 = m_read(bus.rs2_id);
    check("m_rs1_data", bus.rs1_data, e1);
    check("m_rs2_data", bus.rs2_data, e2);
    check("m_DataEqual", 64'(bus.DataEqual), 64'(e1 == e2));
    check("m_hazard", 64'(bus.hazard), 64'(m_src_hazard(bus.rs1_id) || m_src_hazard(bus.rs2_id)));
    check("m_busy_cnt", 64'(bus.busy_cnt), 64'(m_count()));
  endtask

  task automatic apply(input logic [IW-1:0] rs1, input logic [IW-1:0] rs2,
                       input logic [IW-1:0] rd, input logic we, input logic [DW-1:0] wd,
                       input logic iv, input logic [IW-1:0] ird);
    bus.rs1_id      = rs1;
    bus.rs2_id      = rs2;
    bus.rd_id       = rd;
    bus.RegWrite    = we;
    bus.WBdata      = wd;
    bus.issue_valid = iv;
    bus.issue_rd    = ird;
    #1;
  endtask

  // Advance one clock; the model follows the writeback-then-issue rule so issue wins.
  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else begin
      if (bus.RegWrite && bus.rd_id != 0) begin
        m_reg[bus.rd_id]  = bus.WBdata;
        m_busy[bus.rd_id] = 1'b0;
      end
      if (bus.issue_valid && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic exp_out(input string tag, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                         input logic hz, input logic [IW:0] cnt);
    check({tag, "_rs1"}, bus.rs1_data, e1);
    check({tag, "_rs2"}, bus.rs2_data, e2);
    check({tag, "_eq"}, 64'(bus.DataEqual), 64'(e1 == e2));
    check({tag, "_haz"}, 64'(bus.hazard), 64'(hz));
    check({tag, "_cnt"}, 64'(bus.busy_cnt), 64'(cnt));
  endtask

  function automatic vec_t mk(input int rs1, input int rs2, input int rd, input int we,
                              input logic [DW-1:0] wd, input int iv, input int ird,
                              input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                              input int eq, input int hz, input int cnt);
    vec_t v;
    v.rs1 = IW'(rs1); v.rs2 = IW'(rs2); v.rd = IW'(rd); v.we = we[0]; v.wd = wd;
    v.iv = iv[0]; v.ird = IW'(ird); v.e1 = e1; v.e2 = e2; v.eq = eq[0]; v.hz = hz[0];
    v.cnt = (IW+1)'(cnt);
    return v;
  endfunction

  initial begin
    n_pass  = 0;
    n_total = 0;
    //              rs1 rs2 rd we wd            iv ird  e1            e2           eq hz cnt
    vecs[0]  = mk(3, 4, 0, 0, 64'h0,      0, 0, 64'h0,    64'h0,    1, 0, 0);
    vecs[1]  = mk(2, 3, 1, 1, 64'hFF,     0, 0, 64'h0,    64'h0,    1, 0, 0);
    vecs[2]  = mk(1, 3, 2, 1, 64'hFF,     0, 0, 64'hFF,   64'h0,    0, 0, 0);
    vecs[3]  = mk(1, 2, 0, 0, 64'h0,      0, 0, 64'hFF,   64'hFF,   1, 0, 0);
    vecs[4]  = mk(4, 5, 2, 1, 64'hFE,     0, 0, 64'h0,    64'h0,    1, 0, 0);
    vecs[5]  = mk(1, 2, 0, 0, 64'h0,      0, 0, 64'hFF,   64'hFE,   0, 0, 0);
    vecs[6]  = mk(1, 1, 0, 1, 64'hDEAD,   1, 0, 64'hFF,   64'hFF,   1, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 64'h0,      0, 0, 64'h0,    64'h0,    1, 0, 0);
    vecs[8]  = mk(0, 1, 0, 0, 64'h0,      1, 7, 64'h0,    64'hFF,   0, 0, 0);
    vecs[9]  = mk(0, 7, 0, 0, 64'h0,      0, 0, 64'h0,    64'h0,    1, 1, 1);
    vecs[10] = mk(1, 6, 0, 0, 64'h0,      1, 7, 64'hFF,   64'h0,    0, 0, 1);
    vecs[11] = mk(7, 0, 0, 0, 64'h0,      0, 0, 64'h0,    64'h0,    1, 1, 1);
    vecs[12] = mk(2, 1, 8, 1, 64'h10,     0, 0, 64'hFE,   64'hFF,   0, 0, 1);
    vecs[13] = mk(8, 7, 0, 0, 64'h0,      0, 0, 64'h10,   64'h0,    0, 1, 1);

    model_clear();
    rst = 1'b1;
    apply(5'd0, 5'd0, 5'd0, 1'b0, 64'h0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].we, vecs[i].wd, vecs[i].iv, vecs[i].ird);
      check($sformatf("v%0d_rs1", i), bus.rs1_data, vecs[i].e1);
      check($sformatf("v%0d_rs2", i), bus.rs2_data, vecs[i].e2);
      check($sformatf("v%0d_eq", i), 64'(bus.DataEqual), 64'(vecs[i].eq));
      check($sformatf("v%0d_haz", i), 64'(bus.hazard), 64'(vecs[i].hz));
      check($sformatf("v%0d_cnt", i), 64'(bus.busy_cnt), 64'(vecs[i].cnt));
      model_check();
      tick();
    end

    // Writeback of busy x7 clears the scoreboard
    apply(5'd0, 5'd7, 5'd7, 1'b1, 64'h55, 1'b0, 5'd0);
    exp_out("wb7", 64'h0, BYP ? 64'h55 : 64'h0, !BYP, 6'd1);
    model_check(); tick();
    apply(5'd0, 5'd7, 5'd0, 1'b0, 64'h0, 1'b0, 5'd0);
    exp_out("wb7_next", 64'h0, 64'h55, 1'b0, 6'd0);
    model_check(); tick();

    // Bypass on x3 while it is busy
    apply(5'd0, 5'd0, 5'd0, 1'b0, 64'h0, 1'b1, 5'd3);
    model_check(); tick();
    apply(5'd3, 5'd0, 5'd3, 1'b1, 64'hABCD, 1'b0, 5'd0);
    exp_out("byp3", BYP ? 64'hABCD : 64'h0, 64'h0, !BYP, 6'd1);
    model_check(); tick();
    apply(5'd3, 5'd0, 5'd0, 1'b0, 64'h0, 1'b0, 5'd0);
    exp_out("byp3_next", 64'hABCD, 64'h0, 1'b0, 6'd0);
    model_check(); tick();

    // Collision: issue and writeback of x9 in the same cycle
    apply(5'd0, 5'd0, 5'd0, 1'b0, 64'h0, 1'b1, 5'd9);
    model_check(); tick();
    apply(5'd9, 5'd0, 5'd9, 1'b1, 64'h1, 1'b1, 5'd9);
    exp_out("col9", BYP ? 64'h1 : 64'h0, 64'h0, !BYP, 6'd1);
    model_check(); tick();
    apply(5'd9, 5'd0, 5'd0, 1'b0, 64'h0, 1'b0, 5'd0);
    exp_out("col9_next", 64'h1, 64'h0, 1'b1, 6'd1);
    model_check(); tick();
    apply(5'd0, 5'd0, 5'd9, 1'b1, 64'h2, 1'b0, 5'd0);
    model_check(); tick();

    // Reset asserted mid-cycle with writeback and issue in flight
    apply(5'd0, 5'd0, 5'd5, 1'b1, 64'h1234, 1'b1, 5'd11);
    model_check(); tick();
    apply(5'd5, 5'd11, 5'd6, 1'b1, 64'h77, 1'b1, 5'd12);
    exp_out("pre_rst", 64'h1234, 64'h0, 1'b1, 6'd1);
    #1 rst = 1'b1;
    #1;
    model_clear();
    exp_out("in_rst", 64'h0, 64'h0, 1'b0, 6'd0);
    tick();
    rst = 1'b0;
    apply(5'd6, 5'd12, 5'd0, 1'b0, 64'h0, 1'b0, 5'd0);
    exp_out("post_rst", 64'h0, 64'h0, 1'b0, 6'd0);
    model_check(); tick();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [IW-1:0] r1, r2, rd, ird;
      r1  = IW'($urandom_range(0, 15));
      r2  = IW'($urandom_range(0, 15));
      rd  = ($urandom_range(0, 3) == 0) ? r1 : IW'($urandom_range(0, 15));
      ird = ($urandom_range(0, 4) == 0) ? rd : IW'($urandom_range(0, 15));
      apply(r1, r2, rd, 1'($urandom_range(0, 1)), {$urandom, $urandom} & 64'hFFFF_0000_00FF_FFFF,
            1'($urandom_range(0, 1)), ird);
      model_check();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
